// File: rtl/ghost_sprite_arbiter.sv
// ghost_sprite_arbiter: round-robin sharing of the ghost sprite ROM among ghost renderers,
// with registered, id-tagged row return and the skirt animation frame.
module ghost_sprite_arbiter #(
    parameter int NUM_GHOSTS = 4,
    parameter int ROWS       = 14,
    parameter int ANIM_DIV   = 8,
    parameter int BLANK_ADDR = 28,
    localparam int IW = $clog2(NUM_GHOSTS),
    localparam int TW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    frame_tick_i,
    input  logic [NUM_GHOSTS-1:0]   req_i,
    input  logic [4*NUM_GHOSTS-1:0] row_i,
    output logic [4:0]              rom_addr_o,
    input  logic [27:0]             rom_data_i,
    output logic [NUM_GHOSTS-1:0]   ack_o,
    output logic [27:0]             rdata_o,
    output logic                    rvalid_o,
    output logic [IW-1:0]           rid_o,
    output logic                    anim_frame_o
);
    logic [NUM_GHOSTS-1:0] mask_q, mask_d, elig, ack_q;
    logic [IW-1:0]         ptr_q, ptr_d, gid, rid_q;
    logic [TW-1:0]         tick_q, tick_d;
    logic                  anim_q, anim_d, gnt, rvalid_q, wrap;
    logic [27:0]           rdata_q;
    logic [3:0]            sel_row;

    // first eligible ghost at or after the pointer; lower offsets searched last so they win
    always_comb begin
        elig = req_i & ~mask_q;
        gnt  = 1'b0;
        gid  = '0;
        for (int k = NUM_GHOSTS - 1; k >= 0; k--) begin
            if (elig[(int'(ptr_q) + k) % NUM_GHOSTS]) begin
                gnt = 1'b1;
                gid = IW'((int'(ptr_q) + k) % NUM_GHOSTS);
            end
        end
    end

    always_comb begin
        sel_row    = row_i[int'(gid)*4 +: 4];
        rom_addr_o = (gnt && int'(sel_row) < ROWS) ? 5'(int'(anim_q) * ROWS + int'(sel_row))
                                                   : 5'(BLANK_ADDR);
        ptr_d      = gnt ? ((gid == IW'(NUM_GHOSTS - 1)) ? '0 : gid + 1'b1) : ptr_q;
        mask_d     = gnt ? (NUM_GHOSTS'(1) << gid) : '0;
        wrap       = frame_tick_i && (tick_q == TW'(ANIM_DIV - 1));
        tick_d     = wrap ? '0 : (frame_tick_i ? tick_q + 1'b1 : tick_q);
        anim_d     = anim_q ^ wrap;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mask_q   <= '0;
            ptr_q    <= '0;
            tick_q   <= '0;
            anim_q   <= 1'b0;
            ack_q    <= '0;
            rvalid_q <= 1'b0;
            rid_q    <= '0;
            rdata_q  <= '0;
        end else begin
            mask_q   <= mask_d;
            ptr_q    <= ptr_d;
            tick_q   <= tick_d;
            anim_q   <= anim_d;
            ack_q    <= mask_d;
            rvalid_q <= gnt;
            if (gnt) begin
                rid_q   <= gid;
                rdata_q <= rom_data_i;
            end
        end
    end

    assign ack_o        = ack_q;
    assign rvalid_o     = rvalid_q;
    assign rid_o        = rid_q;
    assign rdata_o      = rdata_q;
    assign anim_frame_o = anim_q;
endmodule

// File: tb/tb_ghost_sprite_arbiter.sv
// tb_ghost_sprite_arbiter: directed vectors against ghost_sprite_arbiter with a small sprite ROM model.
module tb_ghost_sprite_arbiter;
    logic        clk = 1'b0, rst = 1'b0, frame_tick = 1'b0;
    logic [3:0]  req = '0;
    logic [15:0] row = '0;
    logic [4:0]  rom_addr;
    logic [27:0] rom_data, rdata;
    logic [3:0]  ack;
    logic        rvalid, anim_frame;
    logic [1:0]  rid;
    int          n_run = 0, n_fail = 0, acks;

    localparam logic [27:0] ROW3  = 28'b0011110101111111110101111100;
    localparam logic [27:0] ROW26 = 28'b1111111100111111110011111111;

    ghost_sprite_arbiter dut (
        .clk_i(clk), .rst_i(rst), .frame_tick_i(frame_tick), .req_i(req), .row_i(row),
        .rom_addr_o(rom_addr), .rom_data_i(rom_data), .ack_o(ack), .rdata_o(rdata),
        .rvalid_o(rvalid), .rid_o(rid), .anim_frame_o(anim_frame)
    );

    function automatic logic [27:0] rom(input logic [4:0] a);
        return (a == 5'd3) ? ROW3 : (a == 5'd26) ? ROW26 : (a >= 5'd28) ? 28'd0 : {a, 23'h155555};
    endfunction

    assign rom_data = rom(rom_addr);

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = '0; row = '0; frame_tick = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_ack", 32'(ack), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_rid", 32'(rid), 0);
        chk("rst_anim", 32'(anim_frame), 0);

        req = 4'b0001; row = 16'h0003;
        #1 chk("t1_addr", 32'(rom_addr), 3);
        step();
        req = '0;
        chk("t1_ack", 32'(ack), 32'b0001);
        chk("t1_rvalid", 32'(rvalid), 1);
        chk("t1_rid", 32'(rid), 0);
        chk("t1_rdata", 32'(rdata), 32'(ROW3));
        step();
        chk("t1_idle_rvalid", 32'(rvalid), 0);
        chk("t1_hold_rdata", 32'(rdata), 32'(ROW3));

        do_reset();
        req = 4'b1111; row = '0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t2_rvalid", 32'(rvalid), 1);
            chk("t2_rid", 32'(rid), 32'(i % 4));
        end
        req = '0;
        step();

        do_reset();
        req = 4'b0100; row = 16'h0500;
        #1 chk("t3_addr", 32'(rom_addr), 5);
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t3_ack_pattern", 32'(ack), (i % 2 == 0) ? 32'b0100 : 0);
            if (ack == 4'b0100) begin
                acks++;
                chk("t3_rid", 32'(rid), 2);
            end
        end
        chk("t3_acks", 32'(acks), 3);
        req = '0;

        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("t4_anim_before", 32'(anim_frame), 0);
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
        end
        chk("t4_anim", 32'(anim_frame), 1);
        req = 4'b0001; row = 16'h000C;
        #1 chk("t4_addr", 32'(rom_addr), 26);
        step();
        chk("t4_ack", 32'(ack), 32'b0001);
        chk("t4_rdata", 32'(rdata), 32'(ROW26));

        req = 4'b0010; row = 16'h00F0;
        #1 chk("t5_addr", 32'(rom_addr), 28);
        step();
        chk("t5_ack", 32'(ack), 32'b0010);
        chk("t5_rid", 32'(rid), 1);
        chk("t5_rdata", 32'(rdata), 0);

        req = 4'b1000; row = 16'h2000;
        #1 chk("t6_addr", 32'(rom_addr), 16);
        rst = 1'b1;
        #1;
        chk("t6_rst_ack", 32'(ack), 0);
        chk("t6_rst_rvalid", 32'(rvalid), 0);
        chk("t6_rst_anim", 32'(anim_frame), 0);
        step();
        rst = 1'b0;
        chk("t6_held_ack", 32'(ack), 0);
        step();
        chk("t6_reack", 32'(ack), 32'b1000);
        chk("t6_rid", 32'(rid), 3);
        chk("t6_rvalid", 32'(rvalid), 1);
        req = '0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
